// File: rtl/multi_cycle_controller.sv
// Main control FSM for the multi-cycle RV32I core.
// Holds only the phase state and the sticky illegal flag; every datapath
// select and enable is decoded from the current state, opcode fields and ALU flags.
module multi_cycle_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [3:0] alu_ctrl,
  output logic [2:0] imm_src,
  output logic       instret,
  output logic       illegal
);

  localparam int unsigned AW = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [AW-1:0] ALU_ADD  = AW'(0);
  localparam logic [AW-1:0] ALU_SUB  = AW'(1);
  localparam logic [AW-1:0] ALU_AND  = AW'(2);
  localparam logic [AW-1:0] ALU_OR   = AW'(3);
  localparam logic [AW-1:0] ALU_XOR  = AW'(4);
  localparam logic [AW-1:0] ALU_SLT  = AW'(5);
  localparam logic [AW-1:0] ALU_SLTU = AW'(6);
  localparam logic [AW-1:0] ALU_SLL  = AW'(7);
  localparam logic [AW-1:0] ALU_SRL  = AW'(8);
  localparam logic [AW-1:0] ALU_SRA  = AW'(9);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
    S_EXEC_I, S_AUIPC, S_LUI, S_ALU_WB, S_BRANCH, S_JALR_ADR, S_JAL, S_TRAP
  } state_t;

  state_t state, state_nxt;
  logic   taken;

  // funct3/alt-bit to ALU operation, shared by register and immediate forms
  function automatic logic [AW-1:0] alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  // State register and sticky illegal flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRAP) illegal <= 1'b1;
    end
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    imm_src = 3'd0;
    case (opcode)
      OP_STORE:         imm_src = 3'd1;
      OP_BRANCH:        imm_src = 3'd2;
      OP_AUIPC, OP_LUI: imm_src = 3'd3;
      OP_JAL:           imm_src = 3'd4;
      default:          imm_src = 3'd0;
    endcase
  end

  // Branch condition from funct3 and the ALU compare flags
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  // Next state and per-state datapath controls
  always_comb begin
    state_nxt  = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;
    instret    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b10;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_AUIPC:          state_nxt = S_AUIPC;
          OP_LUI:            state_nxt = S_LUI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR_ADR;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instret    = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          instret   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_dec(funct3, funct7b5);
        state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_dec(funct3, funct7b5 & (funct3 == 3'b101));
        state_nxt = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_nxt = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        instret   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        // funct3 010/011 has no branch meaning
        if (funct3[2:1] == 2'b01) begin
          state_nxt = S_TRAP;
        end else begin
          pc_write  = taken;
          instret   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_JALR_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = S_JAL;
      end
      S_JAL: begin
        // ALUOut already holds the target; ALU computes the link meanwhile
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_nxt = S_ALU_WB;
      end
      S_TRAP: state_nxt = S_TRAP;
      default: state_nxt = S_TRAP;
    endcase
    // Reset abandons any instruction in flight
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      instret   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized bench for multi_cycle_controller with a per-instruction cycle model.
module tb_multi_cycle_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;
  logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_ctrl;
  logic [2:0] imm_src;
  logic       instret, illegal;

  multi_cycle_controller dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_ctrl(alu_ctrl), .imm_src(imm_src), .instret(instret), .illegal(illegal)
  );

  always #5 clock = ~clock;

  logic [20:0] obs;
  logic [5:0]  enables;
  assign obs = {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_ctrl, imm_src, instret, illegal};
  assign enables = {mem_read, mem_write, ir_write, pc_write, reg_write, instret};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One expected clock cycle: inputs to apply and the full output bundle expected
  typedef struct {
    bit          mr, z, l, lu;
    logic [20:0] exp;
  } cyc_t;

  cyc_t       q[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic [2:0] cur_imm;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                         ITYPE = 7'b0010011, AUIPC = 7'b0010111, LUI = 7'b0110111,
                         BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == STORE) return 3'd1;
    if (op == BR) return 3'd2;
    if (op == AUIPC || op == LUI) return 3'd3;
    if (op == JAL) return 3'd4;
    return 3'd0;
  endfunction

  // Operation names in funct3 order, mapped to the ALU codes
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] plain [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd9;
    return plain[f3];
  endfunction

  function automatic bit taken_of(input logic [2:0] f3, input bit z, input bit l, input bit lu);
    bit c;
    c = (f3[2:1] == 2'b00) ? z : (f3[2:1] == 2'b10) ? l : lu;
    return f3[0] ? !c : c;
  endfunction

  function automatic logic [20:0] ov(input bit mrd, input bit mwr, input bit asrc,
                                     input bit irw, input bit pcw, input bit rgw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] rs, input logic [3:0] alu,
                                     input bit ir, input bit ill);
    return {mrd, mwr, asrc, irw, pcw, rgw, a, b, rs, alu, cur_imm, ir, ill};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input bit mr, input bit z, input bit l, input bit lu, input logic [20:0] e);
    cyc_t c;
    c.mr = mr; c.z = z; c.l = l; c.lu = lu; c.exp = e;
    q.push_back(c);
  endtask

  task automatic push_r(input bit mr, input logic [20:0] e);
    push(mr, rb(), rb(), rb(), e);
  endtask

  // Expected cycle sequence of one instruction (fetch waits wf, memory waits wm)
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input int wf, input int wm, input int zf);
    bit z, l, lu;
    logic [20:0] wb_alu;
    q.delete();
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_imm = imm_of(op);
    wb_alu = ov(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 1, 0);
    for (int i = 0; i < wf; i++) push_r(0, ov(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0));
    push_r(1, ov(1, 0, 0, 1, 1, 0, 2'd0, 2'd2, 2'd0, 4'd0, 0, 0));
    push_r(rb(), ov(0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 4'd0, 0, 0));
    case (op)
      LOAD: begin
        push_r(rb(), ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 4'd0, 0, 0));
        for (int i = 0; i < wm; i++) push_r(0, ov(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0));
        push_r(1, ov(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0));
        push_r(rb(), ov(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 4'd0, 1, 0));
      end
      STORE: begin
        push_r(rb(), ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 4'd0, 0, 0));
        for (int i = 0; i < wm; i++) push_r(0, ov(0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0));
        push_r(1, ov(0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 1, 0));
      end
      RTYPE: begin
        push_r(rb(), ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, alu_of(f3, f7), 0, 0));
        push_r(rb(), wb_alu);
      end
      ITYPE: begin
        push_r(rb(), ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, alu_of(f3, f7 && f3 == 3'd5), 0, 0));
        push_r(rb(), wb_alu);
      end
      AUIPC, LUI: begin
        push_r(rb(), ov(0, 0, 0, 0, 0, 0, (op == LUI) ? 2'd3 : 2'd1, 2'd1, 2'd0, 4'd0, 0, 0));
        push_r(rb(), wb_alu);
      end
      BR: begin
        z = (zf < 0) ? rb() : (zf != 0); l = rb(); lu = rb();
        push(rb(), z, l, lu, ov(0, 0, 0, 0, taken_of(f3, z, l, lu), 0, 2'd2, 2'd0, 2'd0, 4'd1, 1, 0));
      end
      JAL, JALR: begin
        if (op == JALR) push_r(rb(), ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 4'd0, 0, 0));
        push_r(rb(), ov(0, 0, 0, 0, 1, 0, 2'd1, 2'd2, 2'd0, 4'd0, 0, 0));
        push_r(rb(), wb_alu);
      end
      default: begin
        for (int i = 0; i < 12; i++) push_r(rb(), ov(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 1));
      end
    endcase
  endtask

  // Apply one cycle's inputs after the rising edge, compare on the falling edge
  task automatic step(input cyc_t c, input string tag);
    opcode = cur_op; funct3 = cur_f3; funct7b5 = cur_f7;
    mem_ready = c.mr; zero = c.z; lt = c.l; ltu = c.lu;
    @(negedge clock);
    check(tag, 32'(obs), 32'(c.exp));
  endtask

  // Run the queued instruction; exp_cycles < 0 skips the retire-latency check
  task automatic run(input string tag, input int exp_cycles);
    int n, seen;
    cyc_t c;
    n = q.size();
    seen = -1;
    for (int k = 0; k < n; k++) begin
      c = q.pop_front();
      step(c, $sformatf("%s.c%0d", tag, k));
      if (instret === 1'b1 && seen < 0) seen = k + 1;
      @(posedge clock); #1;
    end
    if (exp_cycles >= 0) check({tag, ".cycles"}, 32'(seen), 32'(exp_cycles));
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      check("reset.enables", 32'(enables), 32'd0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
  endtask

  logic [6:0] legal_ops [9] = '{LOAD, STORE, RTYPE, ITYPE, AUIPC, LUI, BR, JAL, JALR};

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int wf, wm;
    cyc_t c;

    reset = 1'b1; opcode = RTYPE; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
    @(posedge clock); #1;
    do_reset(2);
    check("reset.illegal", 32'(illegal), 32'd0);

    build(RTYPE, 3'd0, 1'b1, 0, 0, -1);  run("sub", 4);
    build(LOAD, 3'd2, 1'b0, 0, 3, -1);   run("load_wait3", 8);
    build(BR, 3'd1, 1'b0, 0, 0, 0);      run("bne_taken", 3);
    build(BR, 3'd1, 1'b0, 0, 0, 1);      run("bne_not", 3);
    build(JALR, 3'd0, 1'b0, 0, 0, -1);   run("jalr", 5);
    build(JAL, 3'd0, 1'b0, 0, 0, -1);    run("jal", 4);
    build(STORE, 3'd2, 1'b0, 0, 0, -1);  run("store", 4);
    build(LUI, 3'd0, 1'b0, 2, 0, -1);    run("lui_fwait2", 6);
    build(ITYPE, 3'd0, 1'b1, 0, 0, -1);  run("addi_b5", 4);
    build(ITYPE, 3'd5, 1'b1, 0, 0, -1);  run("srai", 4);

    for (int i = 0; i < 60; i++) begin
      op = legal_ops[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      if (op == BR && f3[2:1] == 2'b01) f3[1] = 1'b0;
      wf = $urandom_range(0, 2);
      wm = $urandom_range(0, 2);
      build(op, f3, rb(), wf, wm, -1);
      run($sformatf("rnd%0d_op%0h", i, op), q.size());
    end

    // Reset during the writeback cycle must suppress every enable
    build(RTYPE, 3'd4, 1'b0, 0, 0, -1);
    for (int k = 0; k < 3; k++) begin
      c = q.pop_front();
      step(c, $sformatf("midrst.c%0d", k));
      @(posedge clock); #1;
    end
    q.delete();
    do_reset(1);
    build(RTYPE, 3'd7, 1'b0, 0, 0, -1);  run("after_midrst", 4);

    // Unsupported opcode traps and stays there
    build(7'b1111111, 3'd0, 1'b0, 0, 0, -1); run("trap", -1);
    build(BR, 3'd2, 1'b0, 0, 0, -1);
    do_reset(1);
    check("trap.cleared", 32'(illegal), 32'd0);
    build(RTYPE, 3'd0, 1'b1, 0, 0, -1);  run("after_trap", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Main control FSM for the team's multi-cycle RV32I core, the successor to the single-cycle processor. It shares one unified instruction/data memory port and one ALU across the phases of each instruction. Each instruction runs as fetch, decode, execute, memory and writeback. The block drives every datapath mux select and write enable, decodes ALU operations, and stalls on a memory ready handshake. The datapath holds PC, OldPC, IR, MDR and ALUOut; this block holds only the FSM state.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero, lt, ltu  in  1 each  ALU flags for the current ALU result: equal, signed less-than, unsigned less-than
- mem_ready  in  1  memory completes the current read or write this cycle
- mem_read, mem_write  out  1  memory request strobes
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write, pc_write, reg_write  out  1  IR, PC and register-file write enables
- alu_src_a  out  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- alu_src_b  out  2  ALU B operand: 00 = rs2, 01 = ImmExt, 10 = constant 4
- result_src  out  2  result bus: 00 = ALUOut, 01 = MDR, 10 = ALU result
- alu_ctrl  out  4  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- imm_src  out  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J (decoded from opcode in every state)
- instret  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  sticky flag for an unsupported opcode

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, AUIPC, LUI, ALU_WB, BRANCH, JALR_ADR, JAL, TRAP.
- FETCH: mem_read=1, adr_src=0.
  - When mem_ready=1: ir_write=1, pc_write=1 with A=PC, B=4, add. Go to DECODE.
  - Otherwise hold FETCH with all enables 0.
- DECODE: A=OldPC, B=ImmExt, add, which precomputes the branch/JAL target into ALUOut. Next state by opcode:
  - 0000011 (load) or 0100011 (store) -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0010111 -> AUIPC
  - 0110111 -> LUI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_ADR
  - any other -> TRAP
- MEM_ADR: A=rs1, B=ImmExt, add. Go to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read=1, adr_src=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: result_src=01, reg_write=1, instret=1. Go to FETCH.
- MEM_WR: mem_write=1, adr_src=1. Hold until mem_ready; when it arrives, instret=1 and go to FETCH.
- EXEC_R: A=rs1, B=rs2. funct3 selects the op: 000 add, or sub when funct7b5=1; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra when funct7b5=1; 110 or; 111 and. Go to ALU_WB.
- EXEC_I: A=rs1, B=ImmExt. Same decode as EXEC_R, except funct7b5 is honoured only for funct3=101. Go to ALU_WB.
- AUIPC: A=OldPC, B=ImmExt, add. Go to ALU_WB.
- LUI: A=zero, B=ImmExt, add. Go to ALU_WB.
- ALU_WB: result_src=00, reg_write=1, instret=1. Go to FETCH.
- BRANCH: A=rs1, B=rs2, sub, result_src=00, instret=1. Go to FETCH.
  - pc_write = taken, where taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010 or 011 -> TRAP instead.
- JALR_ADR: A=rs1, B=ImmExt, add, so ALUOut gets the target. Go to JAL.
- JAL: pc_write=1 with result_src=00 (ALUOut is the target). Same cycle: A=OldPC, B=4, add, which latches the link value into ALUOut. Go to ALU_WB, which writes the link to rd.
- TRAP: all enables 0, illegal=1. Absorbing until reset.
- Every output not listed for a state is 0. alu_ctrl defaults to add.

## Timing
- While reset=1, all enables and strobes are forced to 0. State and illegal clear at the edge. The first FETCH request appears in the first cycle after reset falls.
- The outputs below are combinational from state and flags. pc_write in FETCH is gated by mem_ready; pc_write in BRANCH is gated by taken. mem_read and mem_write are Moore-style and stay steady while the memory waits.
- Minimum cycles per instruction, assuming mem_ready is already high at each request:
  - R-type, I-type, AUIPC, LUI: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
- Each cycle with mem_ready low in FETCH, MEM_RD or MEM_WR adds one cycle.
- instret is exactly one pulse per retired instruction. There is no instret on TRAP.
- If reset asserts mid-instruction, the instruction is abandoned and no write enable asserts in that cycle.

## Test plan
- Reset held for 2 cycles, then released with mem_ready=1 -> cycle after release: state FETCH, mem_read=1, adr_src=0, ir_write=1, pc_write=1, alu_ctrl=0.
- R-type SUB (opcode 0110011, funct3 000, funct7b5=1) -> FETCH, DECODE, EXEC_R with alu_ctrl=1, then ALU_WB with reg_write=1 and instret=1. Total 4 cycles.
- Load with mem_ready held low for 3 cycles in MEM_RD -> mem_read=1 and adr_src=1 held steady throughout. Total 8 cycles; reg_write=1 with result_src=01 in the final cycle.
- BNE (funct3 001) with zero=0 -> pc_write=1 in BRANCH. Repeat with zero=1 -> pc_write=0. Both take 3 cycles.
- JALR -> JALR_ADR, then JAL with pc_write=1, then ALU_WB with reg_write=1. Total 5 cycles.
- Opcode 1111111 -> TRAP after DECODE. illegal=1 and all enables 0 for 10+ cycles. A reset pulse clears illegal and restarts FETCH.
